// File: rtl/reg_writeback_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
//   Shared types for the register-file writeback arbiter.
//   XLEN       : result / write-data width
//   REG_AW     : register address width
//   wb_entry_t : one buffered result {rd, data}
//   wb_sel_t   : which source drives the write port in a given cycle
// ---------------------------------------------------------------------------
package wb_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_MEM
    } wb_sel_t;
endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_if
//   Bundles the ALU result port, the MEM valid/ready port, the register-file
//   write port and (when WB_FWD_EN is defined) the forwarding lookup port.
//   Modports:
//     slave  : arbiter side (consumes results, drives the write port)
//     master : producer / register-file side
//   Optional macro: WB_FWD_EN adds fwd_rs1/2 (in), fwd_hit1/2, fwd_data1/2 (out).
// ---------------------------------------------------------------------------
interface wb_if;
    import wb_pkg::*;

    logic              alu_valid;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              alu_stall;

    logic              mem_valid;
    logic              mem_ready;
    logic [REG_AW-1:0] mem_rd;
    logic [XLEN-1:0]   mem_data;

    logic              regWrite;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   writeData;
    logic              busy;

`ifdef WB_FWD_EN
    logic [REG_AW-1:0] fwd_rs1;
    logic [REG_AW-1:0] fwd_rs2;
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [XLEN-1:0]   fwd_data1;
    logic [XLEN-1:0]   fwd_data2;
`endif

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_stall,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        output regWrite, rd, writeData, busy
`ifdef WB_FWD_EN
        ,
        input  fwd_rs1, fwd_rs2,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_stall,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        input  regWrite, rd, writeData, busy
`ifdef WB_FWD_EN
        ,
        output fwd_rs1, fwd_rs2,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
    );
endinterface

// File: rtl/reg_writeback_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
//   DEPTH-entry FIFO of wb_entry_t holding accepted MEM results.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//     push/pushEntry : write an entry (ignored when full)
//     pop          : drop the head entry (ignored when empty)
//     full/empty   : status from the registered count
//     head         : current oldest entry
//     entryAge/validAge (WB_FWD_EN only): entries re-ordered oldest (index 0)
//                    to youngest, with a valid bit per slot, for forwarding.
//   DEPTH must be a power of two (>= 2) so pointers wrap for free.
// ---------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t pushEntry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
`ifdef WB_FWD_EN
    ,
    output wb_entry_t        entryAge [DEPTH],
    output logic [DEPTH-1:0] validAge
`endif
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    wb_entry_t       memArr [DEPTH];
    logic [AW-1:0]   wrPtrReg, rdPtrReg;
    logic [CNTW-1:0] countReg;
    logic            doPush, doPop;

    assign full   = (countReg == CNTW'(DEPTH));
    assign empty  = (countReg == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign head   = memArr[rdPtrReg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) wrPtrReg <= wrPtrReg + 1'b1;
            if (doPop)  rdPtrReg <= rdPtrReg + 1'b1;
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (doPush) memArr[wrPtrReg] <= pushEntry;
    end

`ifdef WB_FWD_EN
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        logic [AW-1:0] ageIdx;
        assign ageIdx       = rdPtrReg + AW'(gi);
        assign entryAge[gi] = memArr[ageIdx];
        assign validAge[gi] = (CNTW'(gi) < countReg);
    end
`endif
endmodule

// File: rtl/reg_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// reg_writeback_arbiter
//   Writeback front-end for the single register-file write port. Merges a
//   priority single-cycle ALU result with FIFO-buffered MEM results; a starve
//   counter stalls the ALU for one cycle once the FIFO head has waited
//   STARVE_MAX cycles. Writes to x0 are dropped here.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : wb_if.slave (ALU port, MEM valid/ready port, write port, busy,
//              and the forwarding port when WB_FWD_EN is defined)
//   Parameters: DEPTH (FIFO entries, power of 2, >= 2), STARVE_MAX.
//   Optional macro: WB_FWD_EN enables the combinational forwarding lookup.
// ---------------------------------------------------------------------------
module reg_writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input logic clk,
    input logic rst_n,
    wb_if.slave bus
);
    localparam int                 CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]      STARVE_LIM = CW'(STARVE_MAX);

    wb_entry_t         pushEntry, fifoHead;
    logic              fifoFull, fifoEmpty;
    logic              memReady, pushReq, popReq, stall;
    wb_sel_t           sel;
    logic [CW-1:0]     starveReg, starveNext;
    logic              regWriteReg;
    logic [REG_AW-1:0] rdReg;
    logic [XLEN-1:0]   writeDataReg;

`ifdef WB_FWD_EN
    wb_entry_t         entryAge [DEPTH];
    logic [DEPTH-1:0]  validAge;
`endif

    // Gated by rst_n so the producer sees not-ready for the whole reset window.
    assign memReady  = rst_n && !fifoFull;
    // An accepted MEM result aimed at x0 completes its handshake but is not stored.
    assign pushReq   = bus.mem_valid && memReady && (bus.mem_rd != '0);
    assign pushEntry = '{rd: bus.mem_rd, data: bus.mem_data};
    assign stall     = (starveReg == STARVE_LIM) && !fifoEmpty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pushReq),
        .pushEntry (pushEntry),
        .pop       (popReq),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .head      (fifoHead)
`ifdef WB_FWD_EN
        ,
        .entryAge  (entryAge),
        .validAge  (validAge)
`endif
    );

    // Source selection. An ALU result to x0 is consumed without a write and
    // falls through, so the FIFO head may still drain that cycle.
    always_comb begin
        sel = SEL_NONE;
        if (stall)
            sel = SEL_MEM;
        else if (bus.alu_valid && (bus.alu_rd != '0))
            sel = SEL_ALU;
        else if (!fifoEmpty)
            sel = SEL_MEM;
    end

    assign popReq = (sel == SEL_MEM);

    always_comb begin
        starveNext = starveReg;
        if (fifoEmpty || popReq)
            starveNext = '0;
        else if (starveReg != STARVE_LIM)
            starveNext = starveReg + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starveReg    <= '0;
            regWriteReg  <= 1'b0;
            rdReg        <= '0;
            writeDataReg <= '0;
        end else begin
            starveReg <= starveNext;
            case (sel)
                SEL_ALU: begin
                    regWriteReg  <= 1'b1;
                    rdReg        <= bus.alu_rd;
                    writeDataReg <= bus.alu_data;
                end
                SEL_MEM: begin
                    regWriteReg  <= 1'b1;
                    rdReg        <= fifoHead.rd;
                    writeDataReg <= fifoHead.data;
                end
                default: regWriteReg <= 1'b0;   // rd/writeData hold
            endcase
        end
    end

    assign bus.mem_ready = memReady;
    assign bus.alu_stall = stall;
    assign bus.regWrite  = regWriteReg;
    assign bus.rd        = rdReg;
    assign bus.writeData = writeDataReg;
    assign bus.busy      = !fifoEmpty || regWriteReg;

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the youngest match overrides; the pending
    // output register is older than every FIFO entry, so it is checked first.
    always_comb begin
        bus.fwd_hit1  = 1'b0;
        bus.fwd_hit2  = 1'b0;
        bus.fwd_data1 = '0;
        bus.fwd_data2 = '0;
        if (regWriteReg && (rdReg == bus.fwd_rs1) && (bus.fwd_rs1 != '0)) begin
            bus.fwd_hit1  = 1'b1;
            bus.fwd_data1 = writeDataReg;
        end
        if (regWriteReg && (rdReg == bus.fwd_rs2) && (bus.fwd_rs2 != '0)) begin
            bus.fwd_hit2  = 1'b1;
            bus.fwd_data2 = writeDataReg;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (validAge[k] && (entryAge[k].rd == bus.fwd_rs1) && (bus.fwd_rs1 != '0)) begin
                bus.fwd_hit1  = 1'b1;
                bus.fwd_data1 = entryAge[k].data;
            end
            if (validAge[k] && (entryAge[k].rd == bus.fwd_rs2) && (bus.fwd_rs2 != '0)) begin
                bus.fwd_hit2  = 1'b1;
                bus.fwd_data2 = entryAge[k].data;
            end
        end
    end
`endif
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback_arbiter
//   Directed self-checking bench for reg_writeback_arbiter (DEPTH=4,
//   STARVE_MAX=8). Inputs change 1 time unit after the rising edge and
//   outputs are sampled there too. Forwarding checks run when WB_FWD_EN is
//   defined.
// ---------------------------------------------------------------------------
module tb_reg_writeback_arbiter;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checkCnt = 0;
    int   errCnt   = 0;

    wb_if bus();

    reg_writeback_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWrite(input string tag, input logic [4:0] expRd, input logic [31:0] expData);
        checkVal({tag, "_we"},   32'(bus.regWrite), 32'd1);
        checkVal({tag, "_rd"},   32'(bus.rd),       32'(expRd));
        checkVal({tag, "_data"}, bus.writeData,     expData);
    endtask

    // One line per register-file write.
    always @(negedge clk) begin
        if (rst_n && bus.regWrite)
            $display("WB rd=%0d data=%08h", bus.rd, bus.writeData);
    end

    initial begin
        int offer;
        int aluN;
        logic acc, stl;

        rst_n         = 1'b0;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = '0;
        bus.mem_data  = '0;
`ifdef WB_FWD_EN
        bus.fwd_rs1   = '0;
        bus.fwd_rs2   = '0;
`endif
        #2;
        checkVal("rst_we",    32'(bus.regWrite),  32'd0);
        checkVal("rst_rd",    32'(bus.rd),        32'd0);
        checkVal("rst_data",  bus.writeData,      32'd0);
        checkVal("rst_ready", 32'(bus.mem_ready), 32'd0);
        checkVal("rst_stall", 32'(bus.alu_stall), 32'd0);
        checkVal("rst_busy",  32'(bus.busy),      32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checkVal("rel_ready", 32'(bus.mem_ready), 32'd1);

        // ALU only: 1-cycle latency, then rd=0 produces no write.
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        tick();
        checkWrite("alu", 5'd5, 32'hDEADBEEF);
        bus.alu_rd   = 5'd0;
        bus.alu_data = 32'h12345678;
        tick();
        checkVal("alu_x0_we",   32'(bus.regWrite), 32'd0);
        checkVal("alu_x0_hold", 32'(bus.rd),       32'd5);
        bus.alu_valid = 1'b0;
        tick();

        // MEM stream rd=1..4: first write one edge after the push edge.
        for (int i = 1; i <= 5; i++) begin
            bus.mem_valid = (i <= 4);
            bus.mem_rd    = 5'(i);
            bus.mem_data  = 32'h100 + 32'(i);
            checkVal("stream_ready", 32'(bus.mem_ready), 32'd1);
            tick();
            if (i == 1)
                checkVal("stream_first_we", 32'(bus.regWrite), 32'd0);
            else
                checkWrite("stream", 5'(i - 1), 32'h100 + 32'(i - 1));
        end
        bus.mem_valid = 1'b0;
        tick();
        checkVal("stream_idle_we", 32'(bus.regWrite), 32'd0);
        checkVal("stream_busy",    32'(bus.busy),     32'd0);

        // Full + starvation: ALU every cycle, 5 MEM offers.
        offer = 1;
        aluN  = 0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd9;
        for (int e = 1; e <= 11; e++) begin
            bus.mem_valid = (offer <= 5);
            bus.mem_rd    = 5'(offer);
            bus.mem_data  = 32'h200 + 32'(offer);
            bus.alu_data  = 32'hA000 + 32'(aluN);
            checkVal("full_ready", 32'(bus.mem_ready), (e <= 4 || e == 11) ? 32'd1 : 32'd0);
            checkVal("full_stall", 32'(bus.alu_stall), (e == 10) ? 32'd1 : 32'd0);
            acc = bus.mem_ready;
            stl = bus.alu_stall;
            tick();
            if (acc) offer++;
            if (!stl) aluN++;
            if (e == 10)
                checkWrite("starve_mem", 5'd1, 32'h201);
            else
                checkWrite("full_alu", 5'd9, 32'hA000 + ((e <= 9) ? 32'(e - 1) : 32'd9));
        end
        checkVal("full_offers", 32'(offer), 32'd6);
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            tick();
            checkWrite("full_drain", 5'(k), 32'h200 + 32'(k));
        end
        tick();
        checkVal("full_idle_we", 32'(bus.regWrite), 32'd0);
        checkVal("full_busy",    32'(bus.busy),     32'd0);

        // MEM to x0: handshake only, nothing stored.
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd0;
        bus.mem_data  = 32'h333;
        checkVal("x0_ready", 32'(bus.mem_ready), 32'd1);
        tick();
        bus.mem_valid = 1'b0;
        checkVal("x0_busy", 32'(bus.busy), 32'd0);
        tick();
        checkVal("x0_we", 32'(bus.regWrite), 32'd0);

        // Simultaneous push/pop with one entry resident, across pointer wrap.
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd9;
        bus.alu_data  = 32'hC0DE;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd10;
        bus.mem_data  = 32'h30A;
        tick();
        checkWrite("sim_alu", 5'd9, 32'hC0DE);
        bus.alu_valid = 1'b0;
        for (int r = 11; r <= 17; r++) begin
            bus.mem_valid = (r <= 16);
            bus.mem_rd    = 5'(r);
            bus.mem_data  = 32'h300 + 32'(r);
            checkVal("sim_ready", 32'(bus.mem_ready), 32'd1);
            tick();
            checkWrite("sim", 5'(r - 1), 32'h300 + 32'(r - 1));
        end
        checkVal("sim_busy_pend", 32'(bus.busy), 32'd1);
        tick();
        checkVal("sim_idle_we", 32'(bus.regWrite), 32'd0);
        checkVal("sim_busy",    32'(bus.busy),     32'd0);

`ifdef WB_FWD_EN
        // Two FIFO entries for rd=7; youngest must win. ALU keeps the FIFO from draining.
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd9;
        bus.alu_data  = 32'hF00D;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd7;
        bus.mem_data  = 32'h11;
        tick();
        bus.mem_data  = 32'h22;
        tick();
        bus.mem_valid = 1'b0;
        bus.fwd_rs1   = 5'd7;
        bus.fwd_rs2   = 5'd0;
        #1;
        checkVal("fwd_hit1",  32'(bus.fwd_hit1), 32'd1);
        checkVal("fwd_data1", bus.fwd_data1,     32'h22);
        checkVal("fwd_hit2",  32'(bus.fwd_hit2), 32'd0);
        bus.fwd_rs2 = 5'd9;
        #1;
        checkVal("fwd_pend_hit",  32'(bus.fwd_hit2), 32'd1);
        checkVal("fwd_pend_data", bus.fwd_data2,     32'hF00D);
        bus.fwd_rs1   = 5'd0;
        bus.fwd_rs2   = 5'd0;
        bus.alu_valid = 1'b0;
        tick();
        checkWrite("fwd_drain0", 5'd7, 32'h11);
        tick();
        checkWrite("fwd_drain1", 5'd7, 32'h22);
        tick();
        checkVal("fwd_busy", 32'(bus.busy), 32'd0);
`endif

        // Reset mid-stream with 3 entries buffered.
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd9;
        bus.alu_data  = 32'hBBBB;
        for (int p = 1; p <= 3; p++) begin
            bus.mem_valid = 1'b1;
            bus.mem_rd    = 5'(p);
            bus.mem_data  = 32'h400 + 32'(p);
            tick();
        end
        bus.mem_valid = 1'b0;
        checkVal("pre_rst_we",   32'(bus.regWrite), 32'd1);
        checkVal("pre_rst_busy", 32'(bus.busy),     32'd1);
        rst_n = 1'b0;
        #1;
        checkVal("mid_rst_we",    32'(bus.regWrite),  32'd0);
        checkVal("mid_rst_ready", 32'(bus.mem_ready), 32'd0);
        checkVal("mid_rst_busy",  32'(bus.busy),      32'd0);
        checkVal("mid_rst_stall", 32'(bus.alu_stall), 32'd0);
        bus.alu_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checkVal("post_rst_ready", 32'(bus.mem_ready), 32'd1);
        for (int q = 0; q < 4; q++) begin
            tick();
            checkVal("post_rst_we",   32'(bus.regWrite), 32'd0);
            checkVal("post_rst_busy", 32'(bus.busy),     32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end
endmodule
